// File: rtl/multi_cycle_pkg.sv
// rtl/multi_cycle_pkg.sv - shared encodings for the multi-cycle sequencing controller
package multi_cycle_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_EXEC_I    = 4'd4,
    ST_EXEC_LUI  = 4'd5,
    ST_MEM_ADDR  = 4'd6,
    ST_MEM_READ  = 4'd7,
    ST_MEM_WB    = 4'd8,
    ST_MEM_WRITE = 4'd9,
    ST_ALU_WB    = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_HALT      = 4'd12
  } state_e;

  localparam logic [2:0] ALU_OP_FUNCT  = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_PASS_B = 3'b010;
  localparam logic [2:0] ALU_OP_ADD    = 3'b011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;

  // Bit positions of the one-hot instruction class vector
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_LUI    = 5;
  localparam int NUM_CLS    = 6;

endpackage

// File: rtl/op_class_decoder.sv
// rtl/op_class_decoder.sv - opcode to one-hot instruction class plus illegal flag
module op_class_decoder
  import multi_cycle_pkg::*;
(
  input  logic [6:0]         op_i,
  output logic [NUM_CLS-1:0] cls_o,
  output logic               illegal_o
);

  always_comb begin
    cls_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_R:      cls_o[CLS_R]      = 1'b1;
      OP_I:      cls_o[CLS_I]      = 1'b1;
      OP_LOAD:   cls_o[CLS_LOAD]   = 1'b1;
      OP_STORE:  cls_o[CLS_STORE]  = 1'b1;
      OP_BRANCH: cls_o[CLS_BRANCH] = 1'b1;
      OP_LUI:    cls_o[CLS_LUI]    = 1'b1;
      default:   illegal_o         = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle fetch/decode/execute/memory/write-back sequencer
module multi_cycle_control
  import multi_cycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       PC_Write_Cond_o,
  output logic       PC_Src_o,
  output logic       IR_Write_o,
  output logic       I_or_D_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic       Mem_to_Reg_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       Instr_Done_o,
  output logic       Illegal_Op_o,
  output logic [3:0] State_o
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [NUM_CLS-1:0]   op_cls;
  logic                 op_illegal;

  op_class_decoder u_op_class_decoder (
    .op_i      (OP_i),
    .cls_o     (op_cls),
    .illegal_o (op_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:     state_d = ST_FETCH;
      ST_FETCH:     if (Mem_Ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_illegal)                                 state_d = ST_HALT;
        else if (op_cls[CLS_R])                         state_d = ST_EXEC_R;
        else if (op_cls[CLS_I])                         state_d = ST_EXEC_I;
        else if (op_cls[CLS_LUI])                       state_d = ST_EXEC_LUI;
        else if (op_cls[CLS_LOAD] || op_cls[CLS_STORE]) state_d = ST_MEM_ADDR;
        else if (op_cls[CLS_BRANCH])                    state_d = ST_BRANCH;
        else                                            state_d = ST_HALT;
      end
      ST_EXEC_R,
      ST_EXEC_I,
      ST_EXEC_LUI:  state_d = ST_ALU_WB;
      ST_MEM_ADDR: begin
        if (op_cls[CLS_LOAD])       state_d = ST_MEM_READ;
        else if (op_cls[CLS_STORE]) state_d = ST_MEM_WRITE;
        else                        state_d = ST_HALT;
      end
      ST_MEM_READ:  if (Mem_Ready_i) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (Mem_Ready_i) state_d = ST_FETCH;
      ST_MEM_WB,
      ST_ALU_WB,
      ST_BRANCH:    state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_HALT;
    endcase
  end

  // Sticky until reset; the only way out of HALT is reset anyway
  assign illegal_d = illegal_q | (state_d == ST_HALT);

  always_comb begin
    PC_Write_o      = 1'b0;
    PC_Write_Cond_o = 1'b0;
    PC_Src_o        = 1'b0;
    IR_Write_o      = 1'b0;
    I_or_D_o        = 1'b0;
    Mem_Read_o      = 1'b0;
    Mem_Write_o     = 1'b0;
    Reg_Write_o     = 1'b0;
    Mem_to_Reg_o    = 1'b0;
    ALU_Src_A_o     = SRC_A_PC;
    ALU_Src_B_o     = SRC_B_RS2;
    ALU_Op_o        = ALU_OP_FUNCT;
    Instr_Done_o    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = SRC_B_FOUR;
        ALU_Op_o    = ALU_OP_ADD;
        PC_Write_o  = Mem_Ready_i;
        IR_Write_o  = Mem_Ready_i;
      end
      ST_DECODE: begin
        ALU_Src_A_o = SRC_A_OLD_PC;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_ADD;
      end
      ST_EXEC_R: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_RS2;
        ALU_Op_o    = ALU_OP_FUNCT;
      end
      ST_EXEC_I: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_FUNCT;
      end
      ST_EXEC_LUI: begin
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_PASS_B;
      end
      ST_MEM_ADDR: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_ADD;
      end
      ST_MEM_READ: begin
        I_or_D_o   = 1'b1;
        Mem_Read_o = 1'b1;
      end
      ST_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 1'b1;
        Instr_Done_o = 1'b1;
      end
      ST_MEM_WRITE: begin
        I_or_D_o     = 1'b1;
        Mem_Write_o  = 1'b1;
        Instr_Done_o = Mem_Ready_i;
      end
      ST_ALU_WB: begin
        Reg_Write_o  = 1'b1;
        Instr_Done_o = 1'b1;
      end
      ST_BRANCH: begin
        ALU_Src_A_o     = SRC_A_RS1;
        ALU_Src_B_o     = SRC_B_RS2;
        ALU_Op_o        = ALU_OP_BRANCH;
        PC_Write_Cond_o = 1'b1;
        PC_Src_o        = 1'b1;
        Instr_Done_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign Illegal_Op_o = illegal_q;
  assign State_o      = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - self-checking bench for multi_cycle_control
module tb_multi_cycle_control;
  import multi_cycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] OP_i;
  logic       Mem_Ready_i;
  logic       PC_Write_o, PC_Write_Cond_o, PC_Src_o, IR_Write_o, I_or_D_o;
  logic       Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o;
  logic [1:0] ALU_Src_A_o, ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic       Instr_Done_o, Illegal_Op_o;
  logic [3:0] State_o;

  multi_cycle_control dut (
    .clk             (clk),
    .reset           (reset),
    .OP_i            (OP_i),
    .Mem_Ready_i     (Mem_Ready_i),
    .PC_Write_o      (PC_Write_o),
    .PC_Write_Cond_o (PC_Write_Cond_o),
    .PC_Src_o        (PC_Src_o),
    .IR_Write_o      (IR_Write_o),
    .I_or_D_o        (I_or_D_o),
    .Mem_Read_o      (Mem_Read_o),
    .Mem_Write_o     (Mem_Write_o),
    .Reg_Write_o     (Reg_Write_o),
    .Mem_to_Reg_o    (Mem_to_Reg_o),
    .ALU_Src_A_o     (ALU_Src_A_o),
    .ALU_Src_B_o     (ALU_Src_B_o),
    .ALU_Op_o        (ALU_Op_o),
    .Instr_Done_o    (Instr_Done_o),
    .Illegal_Op_o    (Illegal_Op_o),
    .State_o         (State_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] exp;
    logic        rdy;
    logic [6:0]  opc;
  } step_t;

  step_t q[$];
  int    vectors = 0;
  int    miscompares = 0;

  wire logic [21:0] obs = {State_o, PC_Write_o, PC_Write_Cond_o, PC_Src_o, IR_Write_o,
                           I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o,
                           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Instr_Done_o, Illegal_Op_o};

  // Expected outputs of one cycle, taken straight from the per-state output table
  function automatic logic [21:0] outs_for(state_e st, logic rdy);
    logic [3:0] sv;
    logic pcw, pcwc, pcs, irw, iod, mr, mw, rw, m2r, done, ill;
    logic [1:0] a, b;
    logic [2:0] op;
    sv = st;
    {pcw, pcwc, pcs, irw, iod, mr, mw, rw, m2r, done, ill} = '0;
    a = 2'b00; b = 2'b00; op = 3'b000;
    case (st)
      ST_FETCH:     begin mr = 1; b = 2'b01; op = 3'b011; pcw = rdy; irw = rdy; end
      ST_DECODE:    begin a = 2'b01; b = 2'b10; op = 3'b011; end
      ST_EXEC_R:    begin a = 2'b10; b = 2'b00; op = 3'b000; end
      ST_EXEC_I:    begin a = 2'b10; b = 2'b10; op = 3'b000; end
      ST_EXEC_LUI:  begin b = 2'b10; op = 3'b010; end
      ST_MEM_ADDR:  begin a = 2'b10; b = 2'b10; op = 3'b011; end
      ST_MEM_READ:  begin iod = 1; mr = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; done = 1; end
      ST_MEM_WRITE: begin iod = 1; mw = 1; done = rdy; end
      ST_ALU_WB:    begin rw = 1; done = 1; end
      ST_BRANCH:    begin a = 2'b10; b = 2'b00; op = 3'b001; pcwc = 1; pcs = 1; done = 1; end
      ST_HALT:      ill = 1;
      default: ;
    endcase
    return {sv, pcw, pcwc, pcs, irw, iod, mr, mw, rw, m2r, a, b, op, done, ill};
  endfunction

  function automatic bit is_legal(logic [6:0] opc);
    return opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input state_e st, input logic rdy, input logic [6:0] opc);
    step_t s;
    s.exp = outs_for(st, rdy);
    s.rdy = rdy;
    s.opc = opc;
    q.push_back(s);
  endtask

  // Expected cycle trace of one instruction; len is the spec cycle count or -1 for illegal
  task automatic build(input logic [6:0] opc, input int wf, input int wm, input bit idle_rnd,
                       input int n_halt, output int len);
    logic idle;
    for (int i = 0; i < wf; i++) push(ST_FETCH, 1'b0, opc);
    push(ST_FETCH, 1'b1, opc);
    idle = idle_rnd ? 1'($urandom) : 1'b1;
    push(ST_DECODE, idle, opc);
    len = -1;
    case (opc)
      7'b0110011: begin push(ST_EXEC_R, idle, opc);   push(ST_ALU_WB, idle, opc); len = 4 + wf; end
      7'b0010011: begin push(ST_EXEC_I, idle, opc);   push(ST_ALU_WB, idle, opc); len = 4 + wf; end
      7'b0110111: begin push(ST_EXEC_LUI, idle, opc); push(ST_ALU_WB, idle, opc); len = 4 + wf; end
      7'b0000011: begin
        push(ST_MEM_ADDR, idle, opc);
        for (int i = 0; i < wm; i++) push(ST_MEM_READ, 1'b0, opc);
        push(ST_MEM_READ, 1'b1, opc);
        push(ST_MEM_WB, idle, opc);
        len = 5 + wf + wm;
      end
      7'b0100011: begin
        push(ST_MEM_ADDR, idle, opc);
        for (int i = 0; i < wm; i++) push(ST_MEM_WRITE, 1'b0, opc);
        push(ST_MEM_WRITE, 1'b1, opc);
        len = 4 + wf + wm;
      end
      7'b1100011: begin push(ST_BRANCH, idle, opc); len = 3 + wf; end
      default: for (int i = 0; i < n_halt; i++) push(ST_HALT, 1'($urandom), opc);
    endcase
  endtask

  // Apply up to n queued steps (n < 0: all), then drop the remainder
  task automatic run_steps(input int n, output int done_at);
    step_t s;
    int cyc;
    cyc = 0;
    done_at = 0;
    while (q.size() > 0 && (n < 0 || cyc < n)) begin
      s = q.pop_front();
      @(negedge clk);
      OP_i = s.opc;
      Mem_Ready_i = s.rdy;
      #1;
      cyc++;
      check($sformatf("step%0d_st%0d", cyc, s.exp[21:18]), 32'(obs), 32'(s.exp));
      check("mem_exclusive", 32'(Mem_Read_o & Mem_Write_o), 32'd0);
      if (Instr_Done_o === 1'b1 && done_at == 0) done_at = cyc;
    end
    q.delete();
  endtask

  task automatic do_instr(input logic [6:0] opc, input int wf, input int wm, input bit idle_rnd);
    int len, done_at;
    build(opc, wf, wm, idle_rnd, 0, len);
    run_steps(-1, done_at);
    check($sformatf("latency_op%b", opc), 32'(done_at), 32'(len));
  endtask

  // mid: assert reset asynchronously between edges, right after the last sampled step
  task automatic reset_seq(input bit mid);
    if (mid) begin
      #2;
      Mem_Ready_i = 1'b1;
      reset = 1'b0;
      #1;
      check("async_reset_zero", 32'(obs), 32'd0);
    end
    @(negedge clk);
    #1;
    check("reset_held_zero", 32'(obs), 32'd0);
    reset = 1'b1;
    #1;
    check("reset_release", 32'(obs), 32'(outs_for(ST_RESET, 1'b1)));
  endtask

  initial begin
    int len, done_at, k, wf, wm;
    logic [6:0] opc;
    logic [6:0] legal [6];
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};

    reset = 1'b0;
    OP_i = 7'd0;
    Mem_Ready_i = 1'b0;
    reset_seq(1'b0);

    do_instr(7'b0110011, 0, 0, 1'b0);
    do_instr(7'b0000011, 0, 2, 1'b1);
    do_instr(7'b0100011, 3, 0, 1'b1);
    do_instr(7'b1100011, 0, 0, 1'b1);

    build(7'b1111111, 0, 0, 1'b1, 20, len);
    run_steps(-1, done_at);
    check("illegal_no_done", 32'(done_at), 32'd0);
    reset_seq(1'b1);
    do_instr(7'b0110011, 0, 0, 1'b1);

    build(7'b0100011, 0, 5, 1'b1, 0, len);
    run_steps(4, done_at);
    reset_seq(1'b1);
    do_instr(7'b0010011, 1, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 6);
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      if (k < 6) begin
        do_instr(legal[k], wf, wm, 1'b1);
      end else begin
        do opc = 7'($urandom); while (is_legal(opc));
        build(opc, wf, 0, 1'b1, 3, len);
        run_steps(-1, done_at);
        check("rand_illegal_no_done", 32'(done_at), 32'd0);
        reset_seq(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencing controller for the RISC-V core: a Moore/Mealy FSM that steps the shared datapath (single memory port, single ALU, PC, IR, ALUOut) through fetch, decode, execute, memory and write-back. It replaces single-cycle opcode decode when the core runs with one unified, variable-latency memory. It supports R-type, I-logic, load, store, branch and LUI.

## Interface
- No parameters. All encodings come from the shared package.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `OP_i` input 7: opcode field of the IR.
- `Mem_Ready_i` input 1: memory completes the access this cycle.
- `PC_Write_o` output 1: unconditional PC load.
- `PC_Write_Cond_o` output 1: PC load if the ALU zero flag is set.
- `PC_Src_o` output 1: 0 selects the ALU result, 1 selects ALUOut.
- `IR_Write_o` output 1: IR and OldPC load.
- `I_or_D_o` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `Mem_Read_o` output 1: memory read request.
- `Mem_Write_o` output 1: memory write request.
- `Reg_Write_o` output 1: register file write.
- `Mem_to_Reg_o` output 1: write-back select, 1 = MDR.
- `ALU_Src_A_o` output 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALU_Src_B_o` output 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALU_Op_o` output 3: 000 = funct-decoded, 001 = branch compare, 010 = pass B, 011 = forced add.
- `Instr_Done_o` output 1: one-cycle pulse on the final cycle of each instruction.
- `Illegal_Op_o` output 1: sticky, set when an unknown opcode is reached.
- `State_o` output 4: current state, for debug.

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LUI, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB, BRANCH, HALT.
- Any output not listed for a state is 0.
- RESET: all outputs 0. Goes to FETCH.
- FETCH:
  - Outputs: Mem_Read=1, I_or_D=0, A=PC, B=4, op=011, PC_Src=0.
  - PC_Write and IR_Write equal Mem_Ready_i; these are the only Mealy outputs.
  - Stays in FETCH while Mem_Ready_i=0, goes to DECODE when it is 1.
- DECODE:
  - Outputs: A=OldPC, B=imm, op=011. ALUOut captures the branch target.
  - R → EXEC_R; I-logic → EXEC_I; LUI → EXEC_LUI; load or store → MEM_ADDR; branch → BRANCH; any other opcode → HALT.
- EXEC_R: A=rs1, B=rs2, op=000. Goes to ALU_WB.
- EXEC_I: A=rs1, B=imm, op=000. Goes to ALU_WB.
- EXEC_LUI: B=imm, op=010. Goes to ALU_WB.
- MEM_ADDR: A=rs1, B=imm, op=011. Load → MEM_READ; store → MEM_WRITE.
- MEM_READ: I_or_D=1, Mem_Read=1. Waits for Mem_Ready_i, then goes to MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=1, Instr_Done=1. Goes to FETCH.
- MEM_WRITE: I_or_D=1, Mem_Write=1. On the Mem_Ready_i cycle, Instr_Done=1 and next state is FETCH.
- ALU_WB: Reg_Write=1, Mem_to_Reg=0, Instr_Done=1. Goes to FETCH.
- BRANCH: A=rs1, B=rs2, op=001, PC_Write_Cond=1, PC_Src=1, Instr_Done=1. Goes to FETCH.
- HALT: Illegal_Op_o=1 and all write/request outputs 0. Exits only on reset.
- Mem_Read_o and Mem_Write_o are never asserted together.
- A memory request, once raised, holds stable until the cycle in which Mem_Ready_i=1.

## Timing
- Reset is asynchronous. While reset=0, the state is RESET and all outputs are 0, including Illegal_Op_o.
- The first FETCH is one cycle after reset is released.
- Reset asserted mid-instruction aborts the instruction immediately. No partial writes occur after assertion.
- Cycle counts with zero-wait memory (ready in the first request cycle):
  - R, I-logic, LUI: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each cycle of Mem_Ready_i=0 during FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Mem_Ready_i is ignored in every state that does not request memory.
- Every output except PC_Write_o and IR_Write_o is a pure function of the state register.
- PC_Write_o and IR_Write_o depend combinationally on Mem_Ready_i, in FETCH only.

## Structure
- Shared package `multi_cycle_pkg` holds:
  - opcode constants: R 0110011, I-logic 0010011, load 0000011, store 0100011, branch 1100011, LUI 0110111;
  - 4-bit state encodings, with RESET = 0;
  - ALU_Op codes;
  - ALU_Src_A and ALU_Src_B select codes.
- One sub-module, `op_class_decoder`: combinational decode of OP_i into a one-hot instruction class plus an illegal flag. It is used by the DECODE and MEM_ADDR next-state logic.

## Test plan
- Reset, then R-type 0110011 with ready tied to 1 → states FETCH, DECODE, EXEC_R, ALU_WB. Instr_Done high on cycle 4 only; Reg_Write high on cycle 4 only.
- Load 0000011 with Mem_Ready_i low for 2 cycles in MEM_READ → 7 cycles total. Mem_Read and I_or_D=1 held steady while waiting; Mem_to_Reg=1 in MEM_WB.
- Store 0100011 with fetch ready delayed 3 cycles → PC_Write and IR_Write pulse only on the ready cycle. Mem_Write high exactly 1 cycle; Reg_Write stays 0.
- Branch 1100011 → DECODE drives A=01, B=10, op=011. BRANCH drives op=001, PC_Write_Cond=1, PC_Src=1. Back in FETCH on cycle 4.
- Opcode 1111111 → HALT after DECODE, Illegal_Op_o=1 held for 20 cycles with no requests. Reset clears it and FETCH resumes.
- Reset asserted during MEM_WRITE (ready=0) → all outputs 0 in the same cycle; State_o=0.
